frame_divider: RTL and testbench

//  Parametrised frame-rate divider and vsync monitor for the tracking pipeline.

---
 rtl/frame_divider_if.sv | 21 ++
 rtl/frame_divider.sv | 67 ++++++
 tb/tb_frame_divider.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/frame_divider_if.sv
// frame_divider_if: vsync input, channel controls and frame-strobe outputs of the frame divider.
interface frame_divider_if #(
   parameter int CNT_W  = 8,
   parameter int NUM_CH = 2
);
   logic                    vsync_in;
   logic                    enable;
   logic [NUM_CH*CNT_W-1:0] divisor;
   logic [NUM_CH-1:0]       frame_enable;
   logic [CNT_W-1:0]        frame_count;
   logic                    frame_evt;
   logic                    vsync_lost;
   modport master (
      output vsync_in, enable, divisor,
      input  frame_enable, frame_count, frame_evt, vsync_lost
   );
   modport slave (
      input  vsync_in, enable, divisor,
      output frame_enable, frame_count, frame_evt, vsync_lost
   );
endinterface

// File: rtl/frame_divider.sv
// frame_divider: synchronises camera vsync, strobes per-channel divided frame enables, watches for vsync loss.
module frame_divider #(
   parameter int CNT_W        = 8,
   parameter int NUM_CH       = 2,
   parameter int VSYNC_ACT_LO = 1,
   parameter int SYNC_STAGES  = 2,
   parameter int TO_W         = 20,
   parameter int TIMEOUT      = 600000
) (
   input logic            clk,
   input logic            reset,
   frame_divider_if.slave bus
);
   localparam logic ACT = (VSYNC_ACT_LO != 0) ? 1'b0 : 1'b1;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   edge_q, hit_q, hit_d, evt_q, lost_q, lost_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [TO_W-1:0]        wd_q, wd_d;
   logic [CNT_W-1:0]       c_q [NUM_CH];
   logic [CNT_W-1:0]       c_d [NUM_CH];
   logic [CNT_W-1:0]       div [NUM_CH];
   logic [NUM_CH-1:0]      fen_q, fen_d;
   for (genvar g = 0; g < NUM_CH; g++) begin : g_div
      assign div[g] = bus.divisor[g*CNT_W +: CNT_W];
   end
   // hit_q is the detected edge one stage before it appears on frame_evt; all state updates key off it
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], bus.vsync_in};
      hit_d  = (edge_q != ACT) && (sync_q[SYNC_STAGES-1] == ACT);
      cnt_d  = hit_q ? cnt_q + CNT_W'(1) : cnt_q;
      wd_d   = hit_q ? '0 : (wd_q == TO_W'(TIMEOUT) ? wd_q : wd_q + TO_W'(1));
      lost_d = !hit_q && (wd_d == TO_W'(TIMEOUT));
      fen_d  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         fen_d[i] = bus.enable && (div[i] != '0) && hit_q && (c_q[i] >= div[i] - CNT_W'(1));
         c_d[i]   = (!bus.enable || div[i] == '0 || fen_d[i]) ? '0 :
                    (hit_q ? c_q[i] + CNT_W'(1) : c_q[i]);
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q <= {SYNC_STAGES{~ACT}};
         edge_q <= ~ACT;
         hit_q  <= 1'b0;
         evt_q  <= 1'b0;
         cnt_q  <= '0;
         wd_q   <= '0;
         lost_q <= 1'b0;
         fen_q  <= '0;
         for (int i = 0; i < NUM_CH; i++) c_q[i] <= '0;
      end else begin
         sync_q <= sync_d;
         edge_q <= sync_q[SYNC_STAGES-1];
         hit_q  <= hit_d;
         evt_q  <= hit_q;
         cnt_q  <= cnt_d;
         wd_q   <= wd_d;
         lost_q <= lost_d;
         fen_q  <= fen_d;
         for (int i = 0; i < NUM_CH; i++) c_q[i] <= c_d[i];
      end
   end
   assign bus.frame_evt    = evt_q;
   assign bus.frame_count  = cnt_q;
   assign bus.vsync_lost   = lost_q;
   assign bus.frame_enable = fen_q;
endmodule

// File: tb/tb_frame_divider.sv
// tb_frame_divider: directed vector table plus hand-written latency, watchdog, wrap and reset sequences.
module tb_frame_divider;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   frame_divider_if #(.CNT_W(8), .NUM_CH(2)) fd ();
   frame_divider #(.TIMEOUT(100)) dut (.clk(clk), .reset(reset), .bus(fd));
   typedef struct {
      logic [15:0] div;
      logic        en;
      int          n;
      int          e0;
      int          e1;
   } vec_t;
   vec_t v [6];
   int tests = 0, fails = 0, cyc = 0, sent = 0;
   int s0 = 0, s1 = 0, nevt = 0, wide = 0, nocoinc = 0, last_evt = 0;
   int b0, b1, be, lost_at;
   logic [1:0] fen_prev = '0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (fd.frame_evt) begin
         nevt++;
         last_evt = cyc;
      end
      s0 += int'(fd.frame_enable[0]);
      s1 += int'(fd.frame_enable[1]);
      if ((fd.frame_enable & fen_prev) != 0) wide++;
      if (fd.frame_enable != 0 && !fd.frame_evt) nocoinc++;
      fen_prev = fd.frame_enable;
   end
   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic frame();
      @(negedge clk) fd.vsync_in = 1'b0;
      repeat (3) @(negedge clk);
      fd.vsync_in = 1'b1;
      repeat (17) @(negedge clk);
      sent++;
   endtask
   task automatic clear_channels();
      fd.enable = 1'b0;
      repeat (2) @(negedge clk);
      fd.enable = 1'b1;
   endtask
   task automatic edge_latency(input string name);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check(name, int'(fd.frame_evt), int'(k == 3));
         if (k == 3) check({name, "_count"}, int'(fd.frame_count), 1);
      end
      fd.vsync_in = 1'b1;
      repeat (15) @(negedge clk);
      sent = 1;
   endtask
   initial begin
      v[0] = '{16'h0301, 1'b1, 9, 9, 3};
      v[1] = '{16'h0402, 1'b1, 8, 4, 2};
      v[2] = '{16'h0005, 1'b1, 10, 2, 0};
      v[3] = '{16'h0101, 1'b0, 5, 0, 0};
      v[4] = '{16'h0703, 1'b1, 7, 2, 1};
      v[5] = '{16'h0100, 1'b1, 4, 0, 4};
      fd.vsync_in = 1'b1;
      fd.enable   = 1'b1;
      fd.divisor  = 16'h0001;
      repeat (3) @(negedge clk);
      check("rst_evt", int'(fd.frame_evt), 0);
      check("rst_fen", int'(fd.frame_enable), 0);
      check("rst_count", int'(fd.frame_count), 0);
      check("rst_lost", int'(fd.vsync_lost), 0);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      fd.vsync_in = 1'b0;
      b0 = s0;
      edge_latency("latency_evt");
      check("latency_fen0", s0 - b0, 1);
      for (int i = 0; i < 6; i++) begin
         fd.enable = 1'b0;
         repeat (2) @(negedge clk);
         fd.divisor = v[i].div;
         fd.enable  = v[i].en;
         b0 = s0; b1 = s1; be = nevt;
         repeat (v[i].n) frame();
         check($sformatf("vec%0d_ch0", i), s0 - b0, v[i].e0);
         check($sformatf("vec%0d_ch1", i), s1 - b1, v[i].e1);
         check($sformatf("vec%0d_evts", i), nevt - be, v[i].n);
         check($sformatf("vec%0d_count", i), int'(fd.frame_count), sent % 256);
      end
      fd.divisor = 16'h0601;
      clear_channels();
      b1 = s1;
      repeat (4) frame();
      check("mid_d6", s1 - b1, 0);
      fd.divisor = 16'h0201;
      frame();
      check("mid_lower", s1 - b1, 1);
      repeat (4) frame();
      check("mid_d2", s1 - b1, 3);
      fd.divisor = 16'h0001;
      be = nevt;
      repeat (3) frame();
      check("mid_d0", s1 - b1, 3);
      check("mid_d0_evts", nevt - be, 3);
      while (sent % 256 != 255) frame();
      check("wrap_255", int'(fd.frame_count), 255);
      frame();
      check("wrap_0", int'(fd.frame_count), 0);
      lost_at = -1;
      for (int k = 0; k < 300 && lost_at < 0; k++) begin
         @(negedge clk);
         if (fd.vsync_lost) lost_at = cyc;
      end
      check("wd_delay", lost_at - last_evt, 100);
      frame();
      check("wd_clear", int'(fd.vsync_lost), 0);
      check("wd_count", int'(fd.frame_count), sent % 256);
      fd.divisor = 16'h0501;
      clear_channels();
      repeat (2) frame();
      @(negedge clk) fd.vsync_in = 1'b0;
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      check("mrst_evt", int'(fd.frame_evt), 0);
      check("mrst_fen", int'(fd.frame_enable), 0);
      check("mrst_count", int'(fd.frame_count), 0);
      check("mrst_lost", int'(fd.vsync_lost), 0);
      b1 = s1;
      reset = 1'b1;
      edge_latency("mrst_latency");
      repeat (2) frame();
      check("mrst_ch1_cleared", s1 - b1, 0);
      check("strobe_width", wide, 0);
      check("strobe_coincident", nocoinc, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
